alu_result_capture: RTL and testbench
=====================================

Name: alu_result_capture

Overview:
- Downstream stage of the 32-bit datapath ALU. Registers the ALU's combinational result_hi/result_lo into the Z pair (z_hi/z_lo) and, for multiply/divide, into the architectural HI/LO registers.
- Multiply and divide have long combinational paths, so this block enforces a per-op settle time (multicycle path) before capture.
- Handshakes with the control unit via start/busy/done, and supports direct HI/LO writes from the bus (mthi/mtlo).

Parameters:
- MUL_SETTLE, 2, extra cycles to wait before capture for op 15 (multiply); range 0-15
- DIV_SETTLE, 4, extra cycles to wait before capture for op 16 (divide); range 0-15
- ALU_SETTLE, 0, extra cycles for all other op codes; range 0-15

Ports:
- clk  in  1  single clock; all state updates on rising edge
- clr  in  1  reset, asynchronous, active-low; clears all state
- start  in  1  request capture of the ALU operation currently presented
- op  in  5  ALU op code (same encoding the ALU decodes); sampled only when start is accepted
- result_hi  in  32  ALU high result
- result_lo  in  32  ALU low result
- hi_wr  in  1  write bus_in into hi_reg (mthi)
- lo_wr  in  1  write bus_in into lo_reg (mtlo)
- bus_in  in  32  data for hi_wr/lo_wr
- busy  out  1  high while an accepted operation has not yet been captured
- done  out  1  one-cycle pulse; z_hi/z_lo (and HI/LO if mul/div) hold the new result
- z_hi  out  32  captured result_hi
- z_lo  out  32  captured result_lo
- hi_reg  out  32  architectural HI
- lo_reg  out  32  architectural LO
- z_zero  out  1  registered (result_lo == 0), updated at capture
- z_neg  out  1  registered result_lo[31], updated at capture

Behaviour:
- Reset (clr=0, any time, asynchronous): state=IDLE, settle counter=0, op_q=0. busy, done, z_zero and z_neg are 0; z_hi, z_lo, hi_reg and lo_reg are 32'h0. An operation in progress is abandoned with no capture and no done.
- FSM states:
  - IDLE: busy=0, done=0.
  - SETTLE: busy=1.
  - CAPTURE: busy=1.
  - DONE: busy=0, done=1.
- Accepting start:
  - start is accepted only in IDLE or DONE. It is ignored in SETTLE and CAPTURE, with no queuing.
  - On acceptance at edge k: op_q<=op, and N is selected: MUL_SETTLE if op==15, DIV_SETTLE if op==16, ALU_SETTLE otherwise (including undefined codes).
  - If N==0, next state is CAPTURE. Otherwise next state is SETTLE with cnt=N.
- SETTLE: cnt decrements each edge. When cnt==1 the next state is CAPTURE.
- CAPTURE, on the edge leaving it:
  - z_hi<=result_hi, z_lo<=result_lo, z_zero and z_neg are updated.
  - If op_q is 15 or 16, also hi_reg<=result_hi and lo_reg<=result_lo.
  - Next state is DONE.
- Latency: for a start accepted at edge k, capture occurs at edge k+1+N and done is high for the cycle following that edge. Add: capture at k+1. Multiply with default parameters: capture at k+3. Divide with default parameters: capture at k+5.
- DONE lasts one cycle. With no start it returns to IDLE. With start it behaves as IDLE acceptance (back-to-back ops, done and the new accept in the same cycle).
- Upstream must hold A, B and op to the ALU stable from the accept edge through the capture edge. The block uses op_q only; changes on op after acceptance have no effect.
- z_hi is captured for every op, so it is 0 for single-word ops because the ALU drives result_hi=0.
- hi_wr/lo_wr:
  - Accepted in any state and take effect at the next edge.
  - If a mul/div capture hits the same register on the same edge, the capture wins and the bus write is dropped.
  - hi_wr and lo_wr may both be asserted; both registers then load bus_in.
  - Neither affects z_*, busy or done.
- Counter width is 4 bits; parameter values above 15 are illegal.

Test Plan:
- Reset mid-op: start multiply, then assert clr=0 while busy -> all outputs 0 immediately (asynchronously), no done pulse afterwards, and the next start behaves normally.
- Add: op=3, result_lo=32'h0000_0005, start at edge 0 -> busy high for 1 cycle, z_lo=5 and z_hi=0 at edge 1, done pulse in the cycle after edge 1, z_zero=0, z_neg=0, hi_reg and lo_reg unchanged.
- Multiply (defaults): op=15, result_hi=32'h0000_0001, result_lo=32'h8000_0000 -> capture at edge 3, hi_reg=1, lo_reg=32'h8000_0000, z_neg=1, busy high for 3 cycles. A second start at edge 1 is ignored.
- Divide with op changed after accept: op=16 accepted, then op driven to 3 during SETTLE -> capture still at edge 5, and HI/LO are loaded with remainder/quotient.
- Collision: lo_wr=1 with bus_in=32'hDEAD_BEEF on the same edge as a multiply capture with result_lo=32'h1234 -> lo_reg=32'h1234. lo_wr alone while idle -> lo_reg=32'hDEAD_BEEF one edge later.
- Back-to-back: start held high through the done cycle with op=10 and result_lo=0 -> second capture one edge after done, z_zero=1, second done pulse.

Source files
------------

// File: rtl/alu_result_capture.sv
// -----------------------------------------------------------------------------
// alu_result_capture
//
// Downstream capture stage of the 32-bit datapath ALU. A start request latches
// the op code, waits an op-dependent settle time so the long multiply/divide
// combinational paths can resolve, then registers the ALU result into the Z
// pair (and into architectural HI/LO for multiply/divide). The control unit
// sees busy while the operation is in flight and a one-cycle done pulse once
// the captured values are visible. HI/LO can also be written directly from the
// bus (mthi/mtlo).
//
// Ports:
//   clk        in   1   single clock, rising edge
//   clr        in   1   asynchronous active-low reset, clears all state
//   start      in   1   request capture of the op currently presented
//   op         in   5   ALU op code, sampled only when start is accepted
//   result_hi  in  32   ALU high result
//   result_lo  in  32   ALU low result
//   hi_wr      in   1   load bus_in into hi_reg
//   lo_wr      in   1   load bus_in into lo_reg
//   bus_in     in  32   data for hi_wr/lo_wr
//   busy       out  1   accepted op not yet captured
//   done       out  1   one-cycle pulse after capture
//   z_hi       out 32   captured result_hi
//   z_lo       out 32   captured result_lo
//   hi_reg     out 32   architectural HI
//   lo_reg     out 32   architectural LO
//   z_zero     out  1   captured (result_lo == 0)
//   z_neg      out  1   captured result_lo[31]
// -----------------------------------------------------------------------------
module alu_result_capture #(
    parameter int unsigned MUL_SETTLE = 2,
    parameter int unsigned DIV_SETTLE = 4,
    parameter int unsigned ALU_SETTLE = 0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [4:0]  op,
    input  logic [31:0] result_hi,
    input  logic [31:0] result_lo,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] bus_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] z_hi,
    output logic [31:0] z_lo,
    output logic [31:0] hi_reg,
    output logic [31:0] lo_reg,
    output logic        z_zero,
    output logic        z_neg
);

    localparam logic [4:0] OP_MUL = 5'd15;
    localparam logic [4:0] OP_DIV = 5'd16;

    // The settle counter is 4 bits wide; parameters are limited to 0..15.
    localparam logic [3:0] MUL_N = 4'(MUL_SETTLE);
    localparam logic [3:0] DIV_N = 4'(DIV_SETTLE);
    localparam logic [3:0] ALU_N = 4'(ALU_SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;
    logic [4:0]  op_q_r;
    logic [4:0]  op_q_s;
    logic [3:0]  settle_n_s;
    logic        busy_r;
    logic        busy_s;
    logic        done_r;
    logic        done_s;
    logic        capture_s;
    logic        cap_hilo_s;

    logic [31:0] z_hi_r;
    logic [31:0] z_lo_r;
    logic [31:0] hi_reg_r;
    logic [31:0] lo_reg_r;
    logic        z_zero_r;
    logic        z_neg_r;

    // Extra wait cycles before capture for a given op code; undefined codes
    // fall into the generic ALU bucket.
    function automatic logic [3:0] settle_cycles(input logic [4:0] op_code);
        logic [3:0] n;
        case (op_code)
            OP_MUL:  n = MUL_N;
            OP_DIV:  n = DIV_N;
            default: n = ALU_N;
        endcase
        return n;
    endfunction

    // Ops whose result also lands in architectural HI/LO.
    function automatic logic is_muldiv(input logic [4:0] op_code);
        return (op_code == OP_MUL) || (op_code == OP_DIV);
    endfunction

    // Next-state, counter and op-latch logic for the capture sequencer.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        op_q_s     = op_q_r;
        settle_n_s = settle_cycles(op);
        case (state_r)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new start exactly like IDLE (back-to-back ops).
                if (start) begin
                    op_q_s = op;
                    if (settle_n_s == 4'd0) begin
                        state_s = ST_CAPTURE;
                        cnt_s   = 4'd0;
                    end else begin
                        state_s = ST_SETTLE;
                        cnt_s   = settle_n_s;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                cnt_s = cnt_r - 4'd1;
                // <= rather than == so a corrupted zero count cannot wrap and stall.
                if (cnt_r <= 4'd1) begin
                    state_s = ST_CAPTURE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_CAPTURE: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Output decode of the next state so busy/done come straight from flops.
    always_comb begin
        busy_s     = (state_s == ST_SETTLE) || (state_s == ST_CAPTURE);
        done_s     = (state_s == ST_DONE);
        capture_s  = (state_r == ST_CAPTURE);
        cap_hilo_s = capture_s && is_muldiv(op_q_r);
    end

    // Sequencer state, settle counter, latched op and handshake flags.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            op_q_r  <= 5'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            op_q_r  <= op_q_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Z pair and flags load on the edge leaving CAPTURE.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            z_hi_r   <= 32'h0;
            z_lo_r   <= 32'h0;
            z_zero_r <= 1'b0;
            z_neg_r  <= 1'b0;
        end else if (capture_s) begin
            z_hi_r   <= result_hi;
            z_lo_r   <= result_lo;
            z_zero_r <= (result_lo == 32'h0);
            z_neg_r  <= result_lo[31];
        end else begin
            z_hi_r   <= z_hi_r;
            z_lo_r   <= z_lo_r;
            z_zero_r <= z_zero_r;
            z_neg_r  <= z_neg_r;
        end
    end

    // Architectural HI: a mul/div capture overrides a same-edge bus write.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hi_reg_r <= 32'h0;
        end else if (cap_hilo_s) begin
            hi_reg_r <= result_hi;
        end else if (hi_wr) begin
            hi_reg_r <= bus_in;
        end else begin
            hi_reg_r <= hi_reg_r;
        end
    end

    // Architectural LO: same priority as HI.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            lo_reg_r <= 32'h0;
        end else if (cap_hilo_s) begin
            lo_reg_r <= result_lo;
        end else if (lo_wr) begin
            lo_reg_r <= bus_in;
        end else begin
            lo_reg_r <= lo_reg_r;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign z_hi   = z_hi_r;
    assign z_lo   = z_lo_r;
    assign hi_reg = hi_reg_r;
    assign lo_reg = lo_reg_r;
    assign z_zero = z_zero_r;
    assign z_neg  = z_neg_r;

endmodule

// File: tb/tb_alu_result_capture.sv
// -----------------------------------------------------------------------------
// tb_alu_result_capture
//
// Self-checking bench for alu_result_capture. A transaction-level model tracks
// each accepted op as "capture due at edge k+1+N" and compares every DUT output
// against it on each falling edge. Directed scenarios add literal expectations
// for add, multiply, divide, HI/LO collisions, back-to-back ops and reset
// mid-operation, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_alu_result_capture;

    localparam int MUL_N = 2;
    localparam int DIV_N = 4;
    localparam int ALU_N = 0;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [4:0]  op;
    logic [31:0] result_hi;
    logic [31:0] result_lo;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] bus_in;
    logic        busy;
    logic        done;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        z_zero;
    logic        z_neg;

    int tests = 0;
    int fails = 0;

    alu_result_capture #(
        .MUL_SETTLE(MUL_N),
        .DIV_SETTLE(DIV_N),
        .ALU_SETTLE(ALU_N)
    ) dut (
        .clk(clk), .clr(clr), .start(start), .op(op),
        .result_hi(result_hi), .result_lo(result_lo),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .bus_in(bus_in),
        .busy(busy), .done(done), .z_hi(z_hi), .z_lo(z_lo),
        .hi_reg(hi_reg), .lo_reg(lo_reg), .z_zero(z_zero), .z_neg(z_neg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int settle_of(input logic [4:0] o);
        if (o == 5'd15) return MUL_N;
        else if (o == 5'd16) return DIV_N;
        else return ALU_N;
    endfunction

    int          edge_n = 0;
    bit          m_pending = 1'b0;
    int          m_cap_edge = 0;
    bit          m_muldiv = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    logic [31:0] m_z_hi = 32'h0;
    logic [31:0] m_z_lo = 32'h0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;
    bit          m_zero = 1'b0;
    bit          m_neg = 1'b0;
    bit          was_pending;
    bit          capt;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            edge_n = 0; m_pending = 1'b0; m_muldiv = 1'b0; m_cap_edge = 0;
            m_busy = 1'b0; m_done = 1'b0;
            m_z_hi = 32'h0; m_z_lo = 32'h0; m_hi = 32'h0; m_lo = 32'h0;
            m_zero = 1'b0; m_neg = 1'b0;
        end else begin
            was_pending = m_pending;
            capt = m_pending && (edge_n == m_cap_edge);
            m_done = 1'b0;
            if (capt) begin
                m_z_hi = result_hi;
                m_z_lo = result_lo;
                m_zero = (result_lo == 32'h0);
                m_neg  = result_lo[31];
                if (m_muldiv) begin
                    m_hi = result_hi;
                    m_lo = result_lo;
                end
                m_pending = 1'b0;
                m_done = 1'b1;
            end
            if (hi_wr && !(capt && m_muldiv)) m_hi = bus_in;
            if (lo_wr && !(capt && m_muldiv)) m_lo = bus_in;
            if (start && !was_pending) begin
                m_pending  = 1'b1;
                m_cap_edge = edge_n + 1 + settle_of(op);
                m_muldiv   = (op == 5'd15) || (op == 5'd16);
            end
            m_busy = m_pending;
            edge_n++;
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        check("busy",   {31'h0, busy},   {31'h0, m_busy});
        check("done",   {31'h0, done},   {31'h0, m_done});
        check("z_hi",   z_hi,            m_z_hi);
        check("z_lo",   z_lo,            m_z_lo);
        check("hi_reg", hi_reg,          m_hi);
        check("lo_reg", lo_reg,          m_lo);
        check("z_zero", {31'h0, z_zero}, {31'h0, m_zero});
        check("z_neg",  {31'h0, z_neg},  {31'h0, m_neg});
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; op = 5'd0; result_hi = 32'h0; result_lo = 32'h0;
        hi_wr = 1'b0; lo_wr = 1'b0; bus_in = 32'h0;
        #1 clr = 1'b0;
        tick(); tick();
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_hi",   hi_reg, 32'h0);
        clr = 1'b1;
        tick();

        // Add: capture one edge after accept.
        op = 5'd3; result_hi = 32'h0; result_lo = 32'h0000_0005; start = 1'b1;
        tick();
        check("add_busy", {31'h0, busy}, 32'h1);
        start = 1'b0;
        tick();
        check("add_done", {31'h0, done}, 32'h1);
        check("add_zlo",  z_lo, 32'h5);
        check("add_zhi",  z_hi, 32'h0);
        check("add_lo",   lo_reg, 32'h0);
        check("add_neg",  {31'h0, z_neg}, 32'h0);
        tick();

        // Multiply: capture at edge 3, second start at edge 1 ignored.
        op = 5'd15; result_hi = 32'h0000_0001; result_lo = 32'h8000_0000; start = 1'b1;
        tick();
        op = 5'd3;
        tick();
        check("mul_busy1", {31'h0, busy}, 32'h1);
        start = 1'b0;
        tick();
        check("mul_busy2", {31'h0, busy}, 32'h1);
        check("mul_nodone", {31'h0, done}, 32'h0);
        tick();
        check("mul_done", {31'h0, done}, 32'h1);
        check("mul_hi",   hi_reg, 32'h0000_0001);
        check("mul_lo",   lo_reg, 32'h8000_0000);
        check("mul_neg",  {31'h0, z_neg}, 32'h1);
        tick();

        // Divide with op changed during SETTLE: capture still at edge 5.
        op = 5'd16; result_hi = 32'h0000_0007; result_lo = 32'h0000_0003; start = 1'b1;
        tick();
        start = 1'b0; op = 5'd3;
        repeat (4) tick();
        check("div_busy4", {31'h0, busy}, 32'h1);
        tick();
        check("div_done", {31'h0, done}, 32'h1);
        check("div_hi",   hi_reg, 32'h0000_0007);
        check("div_lo",   lo_reg, 32'h0000_0003);
        tick();

        // Collision: capture beats same-edge lo_wr.
        op = 5'd15; result_hi = 32'h0; result_lo = 32'h0000_1234; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        lo_wr = 1'b1; bus_in = 32'hDEAD_BEEF;
        tick();
        check("col_lo", lo_reg, 32'h0000_1234);
        check("col_hi", hi_reg, 32'h0);
        lo_wr = 1'b0;
        tick();
        lo_wr = 1'b1; bus_in = 32'hDEAD_BEEF;
        tick();
        check("mtlo", lo_reg, 32'hDEAD_BEEF);
        lo_wr = 1'b1; hi_wr = 1'b1; bus_in = 32'hCAFE_F00D;
        tick();
        check("both_hi", hi_reg, 32'hCAFE_F00D);
        check("both_lo", lo_reg, 32'hCAFE_F00D);
        check("both_nodone", {31'h0, done}, 32'h0);
        lo_wr = 1'b0; hi_wr = 1'b0;
        tick();

        // Back-to-back with start held through the done cycle.
        op = 5'd10; result_hi = 32'h0; result_lo = 32'h0; start = 1'b1;
        tick();
        tick();
        check("b2b_done1", {31'h0, done}, 32'h1);
        check("b2b_zero1", {31'h0, z_zero}, 32'h1);
        tick();
        check("b2b_busy", {31'h0, busy}, 32'h1);
        check("b2b_gap",  {31'h0, done}, 32'h0);
        start = 1'b0;
        tick();
        check("b2b_done2", {31'h0, done}, 32'h1);
        check("b2b_zero2", {31'h0, z_zero}, 32'h1);
        tick();

        // Reset mid-multiply: asynchronous clear, no done afterwards.
        op = 5'd15; result_hi = 32'h5555_5555; result_lo = 32'h1111_1111; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #1 clr = 1'b0;
        #1;
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_hi",   hi_reg, 32'h0);
        check("arst_zlo",  z_lo, 32'h0);
        tick(); tick();
        clr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("arst_nodone", {31'h0, done}, 32'h0);
        end
        op = 5'd3; result_hi = 32'h0; result_lo = 32'h0000_0009; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("post_rst_zlo", z_lo, 32'h0000_0009);
        check("post_rst_done", {31'h0, done}, 32'h1);

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            start = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 7))
                0, 1, 2: op = 5'd15;
                3, 4:    op = 5'd16;
                default: op = 5'($urandom_range(0, 31));
            endcase
            result_hi = $urandom();
            result_lo = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
            hi_wr  = ($urandom_range(0, 5) == 0);
            lo_wr  = ($urandom_range(0, 5) == 0);
            bus_in = $urandom();
            if ($urandom_range(0, 399) == 0) begin
                #1 clr = 1'b0;
                #1 clr = 1'b1;
            end
        end
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
